secded_data_mem: RTL

- SECDED-protected data memory. It is the responder side of the single-cycle core's load/store interface.
- Address input is ALUResult, store data is WriteData, and the ReadData return feeds the core's Result mux.
- Each stored word is kept as a 39-bit Hamming(39,32) SECDED codeword, written on stores and decoded/corrected on loads.
- A background scrubber FSM walks the array during idle cycles and writes back single-bit corrections. This complements the core's hamming-protected PC and register file.

---
 rtl/secded_pkg.sv | 50 +++++
 rtl/secded_39_32_codec.sv | 38 +++
 rtl/secded_data_mem.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/secded_pkg.sv
// rtl/secded_pkg.sv - Hamming(39,32) SECDED constants, layout and encode helpers
package secded_pkg;

  localparam int DATA_W = 32;
  localparam int CW_W   = 39;
  localparam int CHK_N  = 6;

  localparam int CHK_POS [CHK_N] = '{1, 2, 4, 8, 16, 32};

  // Data bit i lives at codeword position DATA_POS[i]; powers of two are skipped.
  localparam int DATA_POS [DATA_W] = '{
    3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15,
    17, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27, 28, 29, 30, 31,
    33, 34, 35, 36, 37, 38
  };

  typedef logic [CW_W-1:0] codeword_t;

  typedef enum logic [1:0] {
    SCRUB_WAIT  = 2'd0,
    SCRUB_CHECK = 2'd1,
    SCRUB_FIX   = 2'd2
  } scrub_state_t;

  function automatic logic [CHK_N-1:0] syndrome(input codeword_t cw);
    logic [CHK_N-1:0] syn;
    syn = '0;
    for (int b = 1; b < CW_W; b++) begin
      syn = syn ^ (cw[b] ? CHK_N'(b) : '0);
    end
    return syn;
  endfunction

  // Check bits only contribute their own syndrome bit, so the data-only syndrome is the check word.
  function automatic codeword_t encode(input logic [DATA_W-1:0] d);
    codeword_t        cw;
    logic [CHK_N-1:0] s;
    cw = '0;
    for (int i = 0; i < DATA_W; i++) begin
      cw[DATA_POS[i]] = d[i];
    end
    s = syndrome(cw);
    for (int k = 0; k < CHK_N; k++) begin
      cw[CHK_POS[k]] = s[k];
    end
    cw[0] = ^cw[CW_W-1:1];
    return cw;
  endfunction

endpackage

// File: rtl/secded_39_32_codec.sv
// rtl/secded_39_32_codec.sv - combinational SECDED decode and single-bit correction
module secded_39_32_codec
  import secded_pkg::*;
(
  input  logic [CW_W-1:0]   cw,
  output logic [DATA_W-1:0] data,
  output logic [CW_W-1:0]   cw_fixed,
  output logic              se,
  output logic              de
);

  logic [CHK_N-1:0] syn;
  logic             parity_bad;

  always_comb begin
    syn        = syndrome(cw);
    parity_bad = ^cw;
    cw_fixed   = cw;
    se         = 1'b0;
    de         = 1'b0;
    data       = '0;
    // A syndrome pointing past position 38 cannot come from one flipped bit.
    if (parity_bad) begin
      if (syn < CHK_N'(CW_W)) begin
        se            = 1'b1;
        cw_fixed[syn] = ~cw[syn];
      end else begin
        de = 1'b1;
      end
    end else if (syn != '0) begin
      de = 1'b1;
    end
    for (int i = 0; i < DATA_W; i++) begin
      data[i] = cw_fixed[DATA_POS[i]];
    end
  end

endmodule

// File: rtl/secded_data_mem.sv
// rtl/secded_data_mem.sv - SECDED data memory with load correction and background scrubber
module secded_data_mem
  import secded_pkg::*;
#(
  parameter int DEPTH          = 64,
  parameter int ADDR_W         = 6,
  parameter int SCRUB_INTERVAL = 16,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [31:0]       Addr,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic              single_error_flag,
  output logic              double_error_flag,
  input  logic              inj_en,
  input  logic [ADDR_W-1:0] inj_addr,
  input  logic [CW_W-1:0]   inj_mask,
  output logic [CNT_W-1:0]  ce_count,
  output logic [CNT_W-1:0]  de_count,
  output logic [ADDR_W-1:0] scrub_ptr
);

  localparam int TMR_W = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(SCRUB_INTERVAL - 1);

  codeword_t mem [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic              core_access;
  logic              unused_addr_bits;

  assign idx              = Addr[ADDR_W+1:2];
  assign core_access      = MemRead | MemWrite;
  assign unused_addr_bits = ^{Addr[31:ADDR_W+2], Addr[1:0]};

  logic [DATA_W-1:0] core_data;
  codeword_t         core_fix;
  logic              core_se, core_de;
  logic [DATA_W-1:0] scrub_data_unused;
  codeword_t         scrub_fix;
  logic              scrub_se, scrub_de_raw;

  secded_39_32_codec u_core_codec (
    .cw       (mem[idx]),
    .data     (core_data),
    .cw_fixed (core_fix),
    .se       (core_se),
    .de       (core_de)
  );

  secded_39_32_codec u_scrub_codec (
    .cw       (mem[scrub_ptr]),
    .data     (scrub_data_unused),
    .cw_fixed (scrub_fix),
    .se       (scrub_se),
    .de       (scrub_de_raw)
  );

  logic core_ce_ev, core_de_ev;

  assign core_ce_ev        = MemRead & core_se;
  assign core_de_ev        = MemRead & core_de;
  assign ReadData          = MemRead ? core_data : '0;
  assign single_error_flag = core_ce_ev;
  assign double_error_flag = core_de_ev;

  scrub_state_t      state, state_n;
  logic [TMR_W-1:0]  timer, timer_n;
  logic [ADDR_W-1:0] ptr_n;
  codeword_t         fix_cw, fix_cw_n;
  logic              fix_wr, scrub_ce_ev, scrub_de_ev;

  always_comb begin
    state_n     = state;
    timer_n     = timer;
    ptr_n       = scrub_ptr;
    fix_cw_n    = fix_cw;
    fix_wr      = 1'b0;
    scrub_ce_ev = 1'b0;
    scrub_de_ev = 1'b0;
    case (state)
      SCRUB_WAIT: begin
        if (timer == '0) begin
          state_n = SCRUB_CHECK;
          timer_n = TMR_RELOAD;
        end else if (!core_access) begin
          timer_n = timer - TMR_W'(1);
        end
      end
      SCRUB_CHECK: begin
        if (!core_access) begin
          if (scrub_se) begin
            fix_cw_n = scrub_fix;
            state_n  = SCRUB_FIX;
          end else begin
            scrub_de_ev = scrub_de_raw;
            ptr_n       = scrub_ptr + ADDR_W'(1);
            state_n     = SCRUB_WAIT;
          end
        end
      end
      SCRUB_FIX: begin
        // A store to the word being fixed makes the latched correction stale.
        if (MemWrite && idx == scrub_ptr) begin
          ptr_n   = scrub_ptr + ADDR_W'(1);
          state_n = SCRUB_WAIT;
        end else if (!core_access) begin
          fix_wr      = 1'b1;
          scrub_ce_ev = 1'b1;
          ptr_n       = scrub_ptr + ADDR_W'(1);
          state_n     = SCRUB_WAIT;
        end
      end
      default: state_n = SCRUB_WAIT;
    endcase
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                              input logic a, input logic b);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + (CNT_W+1)'(a) + (CNT_W+1)'(b);
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SCRUB_WAIT;
      timer     <= TMR_RELOAD;
      scrub_ptr <= '0;
      fix_cw    <= '0;
      ce_count  <= '0;
      de_count  <= '0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      scrub_ptr <= ptr_n;
      fix_cw    <= fix_cw_n;
      ce_count  <= sat_add(ce_count, core_ce_ev, scrub_ce_ev);
      de_count  <= sat_add(de_count, core_de_ev, scrub_de_ev);
    end
  end

  logic      core_wr;
  codeword_t core_wr_cw;

  assign core_wr    = MemWrite | core_ce_ev;
  assign core_wr_cw = MemWrite ? encode(WriteData) : core_fix;

  // Injection owns its entry for the cycle; writes to other entries still land.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (fix_wr && !(inj_en && inj_addr == scrub_ptr)) begin
        mem[scrub_ptr] <= fix_cw;
      end
      if (core_wr && !(inj_en && inj_addr == idx)) begin
        mem[idx] <= core_wr_cw;
      end
      if (inj_en) begin
        mem[inj_addr] <= mem[inj_addr] ^ inj_mask;
      end
    end
  end

endmodule
